// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply / divide unit owning the Hi/Lo
// registers. Operands are converted to magnitudes when the start is
// accepted. One bit is processed per clock (shift-add multiply or
// restoring divide). A final FIX cycle applies the signs and writes hi/lo.
//
// Ports
//   clock       system clock, rising edge
//   reset       synchronous, active-low
//   start_mult  start signed a*b (accepted only when idle; wins over start_div)
//   start_div   start signed a/b (accepted only when idle)
//   a, b        operands (rs / rt), sampled with the start
//   busy        operation in progress
//   done        one-cycle completion pulse, hi/lo valid in the same cycle
//   div0        one-cycle pulse with done when a divide had b == 0
//   hi, lo      Hi / Lo result registers
//
// state  | meaning
// S_IDLE | waiting for start_mult / start_div
// S_MULT | shift-add multiply, one multiplier bit per edge
// S_DIV  | restoring divide, one quotient bit per edge
// S_FIX  | sign correction, write hi/lo, pulse done

module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
   logic [WIDTH-1:0]     opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic [CW-1:0]        count_q, count_d;
   logic                 sign_q, sign_d;    // product sign or quotient sign
   logic                 rsign_q, rsign_d;  // remainder sign (dividend sign)
   logic                 is_div_q, is_div_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 div0_q, div0_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;

   // Negating the most-negative value wraps back to itself, which read as
   // unsigned is exactly its magnitude 2^(WIDTH-1).
   always_comb begin
      abs_a = a[WIDTH-1] ? -a : a;
      abs_b = b[WIDTH-1] ? -b : b;
   end

   // Multiply step: add multiplicand into the upper half (keeping the carry)
   // when the multiplier LSB is set, then shift the whole product right.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                          : {1'b0, acc_q[2*WIDTH-1:1]};
   end

   // Divide step: the remainder is always below the divisor, so the shifted
   // remainder fits WIDTH bits and bit WIDTH of the difference is its sign.
   always_comb begin
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = rem_sh - {1'b0, opnd_q};
      div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      prod_fix = sign_q  ? -acc_q : acc_q;
      quot_fix = sign_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      count_d  = count_q;
      sign_d   = sign_q;
      rsign_d  = rsign_q;
      is_div_d = is_div_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      div0_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_mult) begin
               acc_d    = {{WIDTH{1'b0}}, abs_b};
               opnd_d   = abs_a;
               sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
               rsign_d  = 1'b0;
               is_div_d = 1'b0;
               count_d  = '0;
               busy_d   = 1'b1;
               state_d  = S_MULT;
            end else if (start_div) begin
               if (b != '0) begin
                  acc_d    = {{WIDTH{1'b0}}, abs_a};
                  opnd_d   = abs_b;
                  sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                  rsign_d  = a[WIDTH-1];
                  is_div_d = 1'b1;
                  count_d  = '0;
                  busy_d   = 1'b1;
                  state_d  = S_DIV;
               end else begin
                  // Divide by zero completes immediately; hi/lo untouched.
                  done_d = 1'b1;
                  div0_d = 1'b1;
               end
            end
         end
         S_MULT: begin
            acc_d   = mul_next;
            count_d = count_q + CW'(1);
            if (count_q == LAST_COUNT) state_d = S_FIX;
         end
         S_DIV: begin
            acc_d   = div_next;
            count_d = count_q + CW'(1);
            if (count_q == LAST_COUNT) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         opnd_q   <= '0;
         count_q  <= '0;
         sign_q   <= 1'b0;
         rsign_q  <= 1'b0;
         is_div_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         count_q  <= count_d;
         sign_q   <= sign_d;
         rsign_q  <= rsign_d;
         is_div_q <= is_div_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         div0_q   <= div0_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed test of mult_div_unit (WIDTH = 32) with
// hand-computed expected results for latency, busy span, hi/lo and flags.

module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div0;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_bad = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .div0       (div0),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge. Drives a start, returns edges until done
   // (0 if it never came) and number of cycles busy was seen high.
   // inj > 0 pulses start_div (100/7) into the edge numbered inj.
   task automatic run_op(input logic do_mult, input logic do_div,
                         input logic [31:0] ia, input logic [31:0] ib,
                         input int inj,
                         output int lat, output int bcyc, output logic busy0);
      start_mult = do_mult;
      start_div  = do_div;
      a = ia;
      b = ib;
      @(posedge clock); #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      busy0 = busy;
      bcyc  = busy ? 1 : 0;
      lat   = 0;
      for (int i = 1; i <= 60; i++) begin
         if (i == inj) begin
            start_div = 1'b1;
            a = 32'd100;
            b = 32'd7;
         end
         @(posedge clock); #1;
         start_div = 1'b0;
         if (busy) bcyc++;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   int   lat, bcyc;
   logic busy0;

   initial begin
      reset = 1'b0;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_hi", 64'(hi), 64'h0);
      chk("rst_lo", 64'(lo), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_div0", 64'(div0), 64'h0);
      reset = 1'b1;
      @(posedge clock); #1;

      // 7 * -3 = -21
      run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, bcyc, busy0);
      chk("m1_lat", 64'(lat), 64'd33);
      chk("m1_busy_cycles", 64'(bcyc), 64'd33);
      chk("m1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("m1_div0", 64'(div0), 64'h0);

      // divide by zero: immediate done+div0, hi/lo untouched, never busy
      @(posedge clock); #1;
      start_div = 1'b1;
      a = 32'd5;
      b = 32'd0;
      @(posedge clock); #1;
      start_div = 1'b0;
      chk("dz_done", 64'(done), 64'h1);
      chk("dz_div0", 64'(div0), 64'h1);
      chk("dz_busy", 64'(busy), 64'h0);
      chk("dz_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      @(posedge clock); #1;
      chk("dz_done_clr", 64'(done), 64'h0);
      chk("dz_div0_clr", 64'(div0), 64'h0);
      chk("dz_busy_after", 64'(busy), 64'h0);

      run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, lat, bcyc, busy0);
      chk("m_maxpos", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
      run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, bcyc, busy0);
      chk("m_maxneg", {hi, lo}, 64'h4000_0000_0000_0000);

      // -7 / 2 = -3 rem -1
      run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcyc, busy0);
      chk("d1_lat", 64'(lat), 64'd33);
      chk("d1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("d1_div0", 64'(div0), 64'h0);
      run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, lat, bcyc, busy0);
      chk("d2_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
      run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcyc, busy0);
      chk("d_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

      // start_div pulsed into edge 10 of a multiply is ignored: -5 * 6 = -30
      run_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd6, 10, lat, bcyc, busy0);
      chk("ign_lat", 64'(lat), 64'd33);
      chk("ign_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);

      // both starts: multiply wins (3*5 = 15; divide would give 0 rem 3)
      run_op(1'b1, 1'b1, 32'd3, 32'd5, 0, lat, bcyc, busy0);
      chk("both_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
      chk("both_done", 64'(done), 64'h1);

      // new start issued in the done cycle is accepted
      run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, lat, bcyc, busy0);
      chk("b2b_busy0", 64'(busy0), 64'h1);
      chk("b2b_lat", 64'(lat), 64'd33);
      chk("b2b_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

      // reset at edge 15 of a divide
      start_div = 1'b1;
      a = 32'hFFFF_FFF9;
      b = 32'd2;
      @(posedge clock); #1;
      start_div = 1'b0;
      repeat (14) @(posedge clock);
      #1;
      chk("pre_rst_busy", 64'(busy), 64'h1);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_done", 64'(done), 64'h0);
      chk("mid_rst_hilo", {hi, lo}, 64'h0);
      reset = 1'b1;
      repeat (40) begin
         @(posedge clock); #1;
         chk("post_rst_quiet", {31'h0, busy, 31'h0, done}, 64'h0);
      end
      chk("post_rst_hilo", {hi, lo}, 64'h0);
      run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, lat, bcyc, busy0);
      chk("m34_lat", 64'(lat), 64'd33);
      chk("m34_hilo", {hi, lo}, 64'h0000_0000_0000_000C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
